serial_word_receiver: RTL and testbench
=======================================

// Module: serial_word_receiver
// PURPOSE
//  Receive end of the 1-bit serial link that the pass-through cell chain drives.
//  Collects framed serial bits from the chain output into WIDTH-bit words.
//  Presents each word on a valid/ready interface through a one-entry output holding register.
//  The serial side cannot be stalled. A completed word that finds the holding register full is dropped and flagged.
// PARAMETERS
//  WIDTH      8   bits per word; legal range 2..32
//  MSB_FIRST  0   0: first serial bit lands in word_data[0]; 1: first bit lands in word_data[WIDTH-1]
// PORTS
//  clk         input   1      single clock; all state updates on its rising edge
//  rst_n       input   1      asynchronous, active-low reset
//  ser_valid   input   1      ser_bit is valid this cycle
//  ser_start   input   1      qualified by ser_valid; marks ser_bit as the first bit of a frame
//  ser_bit     input   1      serial data bit
//  word_valid  output  1      word_data holds an undelivered word
//  word_ready  input   1      consumer accepts the word when word_valid & word_ready
//  word_data   output  WIDTH  assembled word
//  overrun     output  1      sticky: a completed word was dropped because the holding register was full
//  frame_err   output  1      sticky: ser_start arrived in the middle of a frame
//  err_clr     input   1      synchronous clear of overrun and frame_err
// BEHAVIOUR
//  Reset: asserting rst_n low takes effect immediately, including mid-frame or mid-handshake.
//   - Reset values: state=IDLE, bit count=0, shift register=0.
//   - Output reset values: word_valid=0, word_data=0, overrun=0, frame_err=0.
//   - Any partially received frame is lost.
//  State machine has two states:
//   - IDLE:
//     - ser_valid & ser_start: capture ser_bit, set count=1, go to SHIFT.
//     - ser_valid & !ser_start: bit ignored, remain in IDLE.
//   - SHIFT:
//     - ser_valid & !ser_start: capture bit, count+1.
//     - ser_valid & ser_start: set frame_err; discard the partial frame; this bit is bit 0 of a new frame (count=1).
//     - A cycle without ser_valid holds all state; there is no timeout.
//  Word completion:
//   - The cycle in which the WIDTH-th bit is captured is the completion cycle.
//   - On completion, the assembled word goes to the holding register and the FSM returns to IDLE.
//   - If WIDTH=... a ser_start with count==WIDTH-1 is treated as a restart, never as a completion.
//  Holding register:
//   - It is free in the completion cycle if word_valid=0, or if word_valid & word_ready in that same cycle (same-cycle drain and refill).
//   - If free: word_data is loaded and word_valid=1 from the next cycle (latency = 1 clk after the last bit).
//   - If not free: the new word is dropped, overrun is set, and the held word_data/word_valid are unchanged.
//  Handshake:
//   - While word_valid=1 & word_ready=0, word_data is stable.
//   - word_valid falls the cycle after a handshake unless it is refilled in that same cycle.
//  Sticky flags:
//   - overrun and frame_err stay set until err_clr.
//   - If err_clr and a new set event occur in the same cycle, set wins.
//  Bit ordering:
//   - MSB_FIRST=0: bit i of the frame goes to word_data[i].
//   - MSB_FIRST=1: bit i of the frame goes to word_data[WIDTH-1-i].
// TESTING
//  1. WIDTH=8, MSB_FIRST=0, back-to-back bits 1,0,1,1,0,0,1,0 with start on the first bit, word_ready=1
//     -> word_data=8'h4D, word_valid high for exactly one cycle, 1 clk after the last bit.
//  2. Same stimulus with MSB_FIRST=1 -> word_data=8'hB2.
//  3. word_ready=0, two full frames sent -> the first word is held stable, overrun=1, the second word is dropped;
//     then err_clr -> overrun=0 and the first word is still present.
//  4. ser_start after 3 bits, then 8 more bits -> frame_err=1 and a single word built from the 8 new bits.
//  5. The completion cycle coincides with a handshake on the previous word
//     -> no overrun, the new word is visible the next cycle, no gap in word_valid.
//  6. rst_n pulsed low mid-frame and while word_valid=1
//     -> outputs go to 0 immediately; a following clean frame is received correctly.
//  7. ser_valid gaps of 1–3 cycles between bits -> same word as scenario 1.

Source files
------------

// File: rtl/serial_word_receiver_if.sv
// Serial-in / word-out bundle for serial_word_receiver.
// The master modport is the receiver; the slave modport is the serial source and word consumer.
interface serial_word_receiver_if #(
  parameter int WIDTH = 8
);
  logic             ser_valid;
  logic             ser_start;
  logic             ser_bit;
  logic             word_valid;
  logic             word_ready;
  logic [WIDTH-1:0] word_data;
  logic             overrun;
  logic             frame_err;
  logic             err_clr;

  modport master (
    input  ser_valid, ser_start, ser_bit, word_ready, err_clr,
    output word_valid, word_data, overrun, frame_err
  );

  modport slave (
    output ser_valid, ser_start, ser_bit, word_ready, err_clr,
    input  word_valid, word_data, overrun, frame_err
  );
endinterface

// File: rtl/serial_word_receiver.sv
// Assembles framed serial bits into WIDTH-bit words and presents them through a
// one-entry valid/ready holding register; overflow and mid-frame restarts raise sticky flags.
module serial_word_receiver #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input logic                    clk,
  input logic                    rst_n,
  serial_word_receiver_if.master bus
);
  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [WIDTH-1:0] assembled;
  logic             complete;
  logic             frame_err_set;
  logic             hold_free;
  logic             load;
  logic             overrun_set;

  logic             word_valid_r;
  logic [WIDTH-1:0] word_data_r;
  logic             overrun_r;
  logic             frame_err_r;

  // Writes bit b at frame position idx, honouring the configured bit ordering.
  function automatic logic [WIDTH-1:0] place_bit(input logic [WIDTH-1:0] base,
                                                 input logic [CNT_W-1:0] idx,
                                                 input logic             b);
    logic [WIDTH-1:0] w;
    logic [CNT_W-1:0] pos;
    w      = base;
    pos    = (MSB_FIRST != 0) ? (LAST_IDX - idx) : idx;
    w[pos] = b;
    return w;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      shreg <= shreg_n;
    end
  end

  // A start bit always begins a fresh frame, even when it would have been the last bit.
  always_comb begin
    state_n       = state;
    count_n       = count;
    shreg_n       = shreg;
    assembled     = shreg;
    complete      = 1'b0;
    frame_err_set = 1'b0;
    if (bus.ser_valid) begin
      case (state)
        IDLE: begin
          if (bus.ser_start) begin
            shreg_n = place_bit('0, '0, bus.ser_bit);
            count_n = ONE;
            state_n = SHIFT;
          end
        end
        SHIFT: begin
          if (bus.ser_start) begin
            frame_err_set = 1'b1;
            shreg_n       = place_bit('0, '0, bus.ser_bit);
            count_n       = ONE;
          end else begin
            assembled = place_bit(shreg, count, bus.ser_bit);
            if (count == LAST_IDX) begin
              complete = 1'b1;
              state_n  = IDLE;
              count_n  = '0;
              shreg_n  = '0;
            end else begin
              shreg_n = assembled;
              count_n = count + ONE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign hold_free   = !word_valid_r || bus.word_ready;
  assign load        = complete && hold_free;
  assign overrun_set = complete && !hold_free;

  // Holding register refills in the same cycle it drains, so word_valid has no gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_valid_r <= 1'b0;
      word_data_r  <= '0;
      overrun_r    <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      if (load) begin
        word_valid_r <= 1'b1;
        word_data_r  <= assembled;
      end else if (word_valid_r && bus.word_ready) begin
        word_valid_r <= 1'b0;
      end
      overrun_r   <= overrun_set   || (overrun_r   && !bus.err_clr);
      frame_err_r <= frame_err_set || (frame_err_r && !bus.err_clr);
    end
  end

  assign bus.word_valid = word_valid_r;
  assign bus.word_data  = word_data_r;
  assign bus.overrun    = overrun_r;
  assign bus.frame_err  = frame_err_r;
endmodule

// File: tb/tb_serial_word_receiver.sv
// Drives identical serial traffic into an LSB-first and an MSB-first receiver and
// checks both against a bit-queue reference model through a word scoreboard.
module tb_serial_word_receiver;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic ser_valid, ser_start, ser_bit, word_ready, err_clr;

  int tests_run    = 0;
  int tests_failed = 0;

  serial_word_receiver_if #(.WIDTH(WIDTH)) bus0 ();
  serial_word_receiver_if #(.WIDTH(WIDTH)) bus1 ();

  assign bus0.ser_valid  = ser_valid;
  assign bus0.ser_start  = ser_start;
  assign bus0.ser_bit    = ser_bit;
  assign bus0.word_ready = word_ready;
  assign bus0.err_clr    = err_clr;
  assign bus1.ser_valid  = ser_valid;
  assign bus1.ser_start  = ser_start;
  assign bus1.ser_bit    = ser_bit;
  assign bus1.word_ready = word_ready;
  assign bus1.err_clr    = err_clr;

  serial_word_receiver #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  serial_word_receiver #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  // Reference model: frames are kept as a queue of bits; finished words are scoreboarded.
  bit             m_frame[$];
  bit             m_in_frame;
  bit             m_held;
  bit             m_overrun;
  bit             m_frame_err;
  bit             m_done;
  logic [WIDTH-1:0] m_w0, m_w1;
  logic [WIDTH-1:0] exp_q0[$];
  logic [WIDTH-1:0] exp_q1[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_frame.delete();
      exp_q0.delete();
      exp_q1.delete();
      m_in_frame  = 1'b0;
      m_held      = 1'b0;
      m_overrun   = 1'b0;
      m_frame_err = 1'b0;
    end else begin
      m_done = 1'b0;
      if (err_clr) begin
        m_overrun   = 1'b0;
        m_frame_err = 1'b0;
      end
      if (ser_valid) begin
        if (ser_start) begin
          if (m_in_frame) m_frame_err = 1'b1;
          m_frame.delete();
          m_frame.push_back(ser_bit);
          m_in_frame = 1'b1;
        end else if (m_in_frame) begin
          m_frame.push_back(ser_bit);
          if (m_frame.size() == WIDTH) m_done = 1'b1;
        end
      end
      if (m_held && word_ready) m_held = 1'b0;
      if (m_done) begin
        m_w0 = '0;
        m_w1 = '0;
        foreach (m_frame[i]) begin
          m_w0[i]           = m_frame[i];
          m_w1[WIDTH-1-i]   = m_frame[i];
        end
        if (!m_held) begin
          exp_q0.push_back(m_w0);
          exp_q1.push_back(m_w1);
          m_held = 1'b1;
        end else begin
          m_overrun = 1'b1;
        end
        m_frame.delete();
        m_in_frame = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: compares every DUT output against the model away from the clock edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("valid0", bus0.word_valid, m_held);
      checkOutput("valid1", bus1.word_valid, m_held);
      checkOutput("overrun0", bus0.overrun, m_overrun);
      checkOutput("overrun1", bus1.overrun, m_overrun);
      checkOutput("frame_err0", bus0.frame_err, m_frame_err);
      checkOutput("frame_err1", bus1.frame_err, m_frame_err);
      if (m_held && exp_q0.size() > 0 && exp_q1.size() > 0) begin
        checkOutput("data0", bus0.word_data, exp_q0[0]);
        checkOutput("data1", bus1.word_data, exp_q1[0]);
        if (word_ready) begin
          void'(exp_q0.pop_front());
          void'(exp_q1.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic s, input logic b, input logic r, input logic c);
    @(posedge clk);
    #1;
    ser_valid  = v;
    ser_start  = s;
    ser_bit    = b;
    word_ready = r;
    err_clr    = c;
  endtask

  task automatic sendFrame(input logic [WIDTH-1:0] w, input int gmin, input int gmax,
                           input logic rdy, input logic rdy_last);
    for (int i = 0; i < WIDTH; i++) begin
      applyStimulus(1'b1, i == 0, w[i], (i == WIDTH - 1) ? rdy_last : rdy, 1'b0);
      if (i != WIDTH - 1 && gmax > 0)
        repeat ($urandom_range(gmax, gmin)) applyStimulus(1'b0, 1'b0, 1'b0, rdy, 1'b0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    ser_valid  = 1'b0;
    ser_start  = 1'b0;
    ser_bit    = 1'b0;
    word_ready = 1'b0;
    err_clr    = 1'b0;
    #12;
    checkOutput("rst_valid", bus0.word_valid, 0);
    checkOutput("rst_data", bus0.word_data, 0);
    checkOutput("rst_overrun", bus0.overrun, 0);
    checkOutput("rst_frame_err", bus1.frame_err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic frame, both bit orders; word visible for exactly one cycle.
    sendFrame(8'h4D, 0, 0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("s1_valid", bus0.word_valid, 1);
    checkOutput("s1_data0", bus0.word_data, 32'h4D);
    checkOutput("s2_data1", bus1.word_data, 32'hB2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("s1_one_cycle", bus0.word_valid, 0);

    // Overrun with a stalled consumer, then clear.
    sendFrame(8'h3C, 0, 0, 1'b0, 1'b0);
    sendFrame(8'h71, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("s3_overrun", bus0.overrun, 1);
    checkOutput("s3_held0", bus0.word_data, 32'h3C);
    checkOutput("s3_held1", bus1.word_data, 32'h3C);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("s3_cleared", bus0.overrun, 0);
    checkOutput("s3_still_valid", bus0.word_valid, 1);
    checkOutput("s3_still_data", bus0.word_data, 32'h3C);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Restart after three bits.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    sendFrame(8'h96, 0, 0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("s4_frame_err", bus0.frame_err, 1);
    checkOutput("s4_data0", bus0.word_data, 32'h96);
    checkOutput("s4_data1", bus1.word_data, 32'h69);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Completion coincides with draining the previous word.
    sendFrame(8'h5A, 0, 0, 1'b0, 1'b0);
    sendFrame(8'hC3, 0, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("s5_valid", bus0.word_valid, 1);
    checkOutput("s5_no_overrun", bus0.overrun, 0);
    checkOutput("s5_data0", bus0.word_data, 32'hC3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset while a word is held, a frame is partial and frame_err is set.
    sendFrame(8'hE7, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("s6_valid", bus0.word_valid, 0);
    checkOutput("s6_data", bus0.word_data, 0);
    checkOutput("s6_frame_err", bus1.frame_err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    sendFrame(8'h4D, 0, 0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("s6_after0", bus0.word_data, 32'h4D);
    checkOutput("s6_after1", bus1.word_data, 32'hB2);

    // Gapped serial stream.
    sendFrame(8'h4D, 1, 3, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("s7_data0", bus0.word_data, 32'h4D);
    checkOutput("s7_data1", bus1.word_data, 32'hB2);

    // Random traffic, stalls, restarts and clears.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom % 4) != 0, ($urandom % 12) == 0, $urandom % 2,
                    ($urandom % 3) != 0, ($urandom % 60) == 0);
    end
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
